// File: rtl/wb_timer_if.sv
// wb_if: pipelined Wishbone bus bundle between a wbxbar slave output and a
// slave block.
//
// Ports: clk, rst (shared with the attached block).
// Signals: cyc, stb, we, adr[31:0], sel[3:0], write data, read data, stall,
//          ack, err.
//
// Macro NO_MODPORT_EXPRESSIONS: when defined, write/read data are named
// dat_m/dat_s. Otherwise they are named dat_i/dat_o, as seen from the slave.
interface wb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        stall;
    logic        ack;
    logic        err;
`ifdef NO_MODPORT_EXPRESSIONS
    logic [31:0] dat_m;
    logic [31:0] dat_s;

    modport slave  (input clk, rst, cyc, stb, we, adr, sel, dat_m,
                    output dat_s, stall, ack, err);
    modport master (input clk, rst, dat_s, stall, ack, err,
                    output cyc, stb, we, adr, sel, dat_m);
`else
    logic [31:0] dat_i;
    logic [31:0] dat_o;

    modport slave  (input clk, rst, cyc, stb, we, adr, sel, dat_i,
                    output dat_o, stall, ack, err);
    modport master (input clk, rst, dat_o, stall, ack, err,
                    output cyc, stb, we, adr, sel, dat_i);
`endif
endinterface

// File: rtl/wb_timer.sv
// wb_timer: RISC-V style machine timer (64-bit mtime/mtimecmp) behind a
// pipelined Wishbone slave port.
//
// Ports:
//   clk       - clock (same net as wb.clk)
//   rst       - synchronous active-high reset (same net as wb.rst)
//   wb        - wb_if.slave, never stalls, one ack/err per request in the
//               next cycle
//   timer_irq - registered irq_en & (mtime >= mtimecmp)
//
// Register map (adr[4:2]): 0x00 MTIME_LO, 0x04 MTIME_HI (shadow captured by
// MTIME_LO read), 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL
// (bit0 enable, bit1 irq_en), 0x14 PRESCALE. Any other offset responds
// with err.
//
// Macro WB_TIMER_PRESCALER_EN: when defined, adds the 16-bit PRESCALE
// register and its tick divider. When it is undefined, mtime ticks every
// enabled cycle and 0x14 responds with err.
module wb_timer (
    input  logic clk,
    input  logic rst,
    wb_if.slave  wb,
    output logic timer_irq
);
    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_PRESCALE = 3'd5;

    // Byte-lane merge: lanes with sel set take new data, the others hold.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel_v);
        lane_merge = {sel_v[3] ? new_v[31:24] : old_v[31:24],
                      sel_v[2] ? new_v[23:16] : old_v[23:16],
                      sel_v[1] ? new_v[15:8]  : old_v[15:8],
                      sel_v[0] ? new_v[7:0]   : old_v[7:0]};
    endfunction

    logic [63:0] mtime_r;
    logic [63:0] mtimecmp_r;
    logic [31:0] shadow_r;
    logic        enable_r;
    logic        irq_en_r;
    logic        ack_r;
    logic        err_r;
    logic [31:0] rdat_r;
    logic        irq_r;

    logic [31:0] wdat_s;
    logic        req_s;
    logic        wr_s;
    logic        rd_s;
    logic [2:0]  off_s;
    logic        valid_s;
    logic [31:0] rd_val_s;
    logic        tick_s;
    logic [63:0] mtime_nxt_s;
    logic        unused_s;

`ifdef NO_MODPORT_EXPRESSIONS
    assign wdat_s   = wb.dat_m;
    assign wb.dat_s = wb.cyc ? rdat_r : 32'h0000_0000;
`else
    assign wdat_s   = wb.dat_i;
    assign wb.dat_o = wb.cyc ? rdat_r : 32'h0000_0000;
`endif

    // Responses are registered but suppressed if the master abandons the cycle.
    assign wb.stall  = 1'b0;
    assign wb.ack    = ack_r & wb.cyc;
    assign wb.err    = err_r & wb.cyc;
    assign timer_irq = irq_r;

    assign req_s = wb.cyc & wb.stb;
    assign wr_s  = req_s & wb.we;
    assign rd_s  = req_s & ~wb.we;
    assign off_s = wb.adr[4:2];

    // Address bits outside [4:2] are decoded by the crossbar, not here.
    assign unused_s = ^{wb.adr[31:5], wb.adr[1:0], wb.clk, wb.rst};

`ifdef WB_TIMER_PRESCALER_EN
    logic [15:0] prescale_r;
    logic [15:0] pre_cnt_r;
    logic        wr_pre_s;

    assign wr_pre_s = wr_s & (off_s == OFF_PRESCALE);
    assign tick_s   = enable_r & (pre_cnt_r == prescale_r);

    // Prescale register and its divider counter; a write or disable restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_r <= 16'h0000;
            pre_cnt_r  <= 16'h0000;
        end else begin
            if (wr_pre_s) begin
                prescale_r <= {wb.sel[1] ? wdat_s[15:8] : prescale_r[15:8],
                               wb.sel[0] ? wdat_s[7:0]  : prescale_r[7:0]};
            end
            if (!enable_r || wr_pre_s || tick_s) begin
                pre_cnt_r <= 16'h0000;
            end else begin
                pre_cnt_r <= pre_cnt_r + 16'h0001;
            end
        end
    end
`else
    assign tick_s = enable_r;
`endif

    // Register read mux and offset validity.
    always_comb begin
        valid_s  = 1'b0;
        rd_val_s = 32'h0000_0000;
        case (off_s)
            OFF_MTIME_LO: begin valid_s = 1'b1; rd_val_s = mtime_r[31:0];     end
            OFF_MTIME_HI: begin valid_s = 1'b1; rd_val_s = shadow_r;          end
            OFF_CMP_LO:   begin valid_s = 1'b1; rd_val_s = mtimecmp_r[31:0];  end
            OFF_CMP_HI:   begin valid_s = 1'b1; rd_val_s = mtimecmp_r[63:32]; end
            OFF_CTRL: begin
                valid_s  = 1'b1;
                rd_val_s = {30'h0000_0000, irq_en_r, enable_r};
            end
            OFF_PRESCALE: begin
`ifdef WB_TIMER_PRESCALER_EN
                valid_s  = 1'b1;
                rd_val_s = {16'h0000, prescale_r};
`else
                valid_s  = 1'b0;
                rd_val_s = 32'h0000_0000;
`endif
            end
            default: begin
                valid_s  = 1'b0;
                rd_val_s = 32'h0000_0000;
            end
        endcase
    end

    // Next mtime: a bus write to either half freezes counting for that cycle.
    always_comb begin
        mtime_nxt_s = mtime_r;
        if (wr_s && (off_s == OFF_MTIME_LO)) begin
            mtime_nxt_s = {mtime_r[63:32], lane_merge(mtime_r[31:0], wdat_s, wb.sel)};
        end else if (wr_s && (off_s == OFF_MTIME_HI)) begin
            mtime_nxt_s = {lane_merge(mtime_r[63:32], wdat_s, wb.sel), mtime_r[31:0]};
        end else if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end
    end

    // Timer state: mtime, shadow, mtimecmp and control bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_r    <= 64'h0000_0000_0000_0000;
            shadow_r   <= 32'h0000_0000;
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
            enable_r   <= 1'b0;
            irq_en_r   <= 1'b0;
        end else begin
            mtime_r <= mtime_nxt_s;
            // Reading the low half snapshots the high half for a coherent 64-bit read.
            if (rd_s && (off_s == OFF_MTIME_LO)) begin
                shadow_r <= mtime_r[63:32];
            end
            if (wr_s && (off_s == OFF_CMP_LO)) begin
                mtimecmp_r[31:0] <= lane_merge(mtimecmp_r[31:0], wdat_s, wb.sel);
            end
            if (wr_s && (off_s == OFF_CMP_HI)) begin
                mtimecmp_r[63:32] <= lane_merge(mtimecmp_r[63:32], wdat_s, wb.sel);
            end
            if (wr_s && (off_s == OFF_CTRL) && wb.sel[0]) begin
                enable_r <= wdat_s[0];
                irq_en_r <= wdat_s[1];
            end
        end
    end

    // Bus response and interrupt registers; a request during reset gets no response.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_r  <= 1'b0;
            err_r  <= 1'b0;
            rdat_r <= 32'h0000_0000;
            irq_r  <= 1'b0;
        end else begin
            ack_r  <= req_s & valid_s;
            err_r  <= req_s & ~valid_s;
            rdat_r <= (rd_s && valid_s) ? rd_val_s : 32'h0000_0000;
            irq_r  <= irq_en_r & (mtime_r >= mtimecmp_r);
        end
    end
endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// behavioural register-level model of the timer.
module tb_wb_timer;
`ifdef WB_TIMER_PRESCALER_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [31:0] rdat;
    logic        irq;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    wb_if wbi (.clk(clk), .rst(rst));

    assign wbi.cyc = cyc;
    assign wbi.stb = stb;
    assign wbi.we  = we;
    assign wbi.adr = adr;
    assign wbi.sel = sel;
`ifdef NO_MODPORT_EXPRESSIONS
    assign wbi.dat_m = wdat;
    assign rdat      = wbi.dat_s;
`else
    assign wbi.dat_i = wdat;
    assign rdat      = wbi.dat_o;
`endif

    wb_timer dut (.clk(clk), .rst(rst), .wb(wbi), .timer_irq(irq));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else pass_cnt++;
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_time, m_cmp;
    logic [31:0] m_shadow, m_dat;
    logic        m_en, m_irqen, m_ack, m_err, m_irq;
    logic [15:0] m_pre, m_cnt;

    function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] off);
        case (off)
            3'd0: return m_time[31:0];
            3'd1: return m_shadow;
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return {30'd0, m_irqen, m_en};
            3'd5: return PRE_EN ? {16'd0, m_pre} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin : ref_model
        logic [63:0] t_n;
        logic [31:0] p_n;
        logic [2:0]  off;
        logic        acc, wr, vld, tk, pre_wr;
        if (rst) begin
            m_time <= 64'd0; m_shadow <= 32'd0; m_cmp <= '1;
            m_en <= 1'b0; m_irqen <= 1'b0; m_pre <= 16'd0; m_cnt <= 16'd0;
            m_ack <= 1'b0; m_err <= 1'b0; m_dat <= 32'd0; m_irq <= 1'b0;
        end else begin
            acc    = cyc && stb;
            wr     = acc && we;
            off    = adr[4:2];
            vld    = (off <= 3'd4) || (PRE_EN && off == 3'd5);
            pre_wr = PRE_EN && wr && off == 3'd5;
            m_ack <= acc && vld;
            m_err <= acc && !vld;
            m_dat <= (acc && !we && vld) ? m_read(off) : 32'd0;
            m_irq <= m_irqen && (m_time >= m_cmp);
            tk = m_en && (!PRE_EN || m_cnt == m_pre);
            t_n = m_time;
            if (wr && off == 3'd0)      t_n[31:0]  = lanes(m_time[31:0], wdat, sel);
            else if (wr && off == 3'd1) t_n[63:32] = lanes(m_time[63:32], wdat, sel);
            else if (tk)                t_n = m_time + 64'd1;
            m_time <= t_n;
            if (acc && !we && off == 3'd0) m_shadow <= m_time[63:32];
            if (wr && off == 3'd2) m_cmp[31:0]  <= lanes(m_cmp[31:0], wdat, sel);
            if (wr && off == 3'd3) m_cmp[63:32] <= lanes(m_cmp[63:32], wdat, sel);
            if (wr && off == 3'd4 && sel[0]) begin
                m_en    <= wdat[0];
                m_irqen <= wdat[1];
            end
            p_n = lanes({16'd0, m_pre}, wdat, sel);
            if (pre_wr) m_pre <= p_n[15:0];
            if (!m_en || pre_wr || tk) m_cnt <= 16'd0;
            else m_cnt <= m_cnt + 16'd1;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("stall", wbi.stall, 1'b0);
            check("ack", wbi.ack, m_ack & cyc);
            check("err", wbi.err, m_err & cyc);
            check("rdata", rdat, (m_ack && cyc) ? m_dat : 32'd0);
            check("timer_irq", irq, m_irq);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic ak, output logic er);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rd = rdat; ak = wbi.ack; er = wbi.err;
        @(posedge clk); #1;
        cyc = 1'b0;
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic ak, er;
        xfer(1'b1, a, 4'hF, d, rd, ak, er);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic ak, er;
        int w;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 32'd0; sel = 4'd0; wdat = 32'd0;
        @(posedge clk); #1;
        chk_on = 1'b1;
        idle(2);
        @(negedge clk);
        check("reset_ack", wbi.ack, 1'b0);
        check("reset_err", wbi.err, 1'b0);
        check("reset_irq", irq, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // enable, idle 10, read MTIME_LO
        wr32(32'h10, 32'h1);
        idle(10);
        xfer(1'b0, 32'h0, 4'hF, 32'h0, rd, ak, er);
        check("mtime_read_ack", ak, 1'b1);
        check("mtime_read_range", (rd >= 32'h0A && rd <= 32'h0C), 1'b1);

        // carry into the high half and shadow coherence
        wr32(32'h10, 32'h0);
        wr32(32'h00, 32'hFFFF_FFFF);
        wr32(32'h04, 32'h0);
        wr32(32'h10, 32'h1);
        idle(5);
        xfer(1'b0, 32'h0, 4'hF, 32'h0, rd, ak, er);
        check("carry_lo", rd, 32'h5);
        xfer(1'b0, 32'h4, 4'hF, 32'h0, rd, ak, er);
        check("shadow_hi", rd, 32'h1);

        // compare interrupt rise and fall
        wr32(32'h10, 32'h0);
        wr32(32'h00, 32'h0);
        wr32(32'h04, 32'h0);
        wr32(32'h08, 32'd100);
        wr32(32'h0C, 32'h0);
        wr32(32'h10, 32'h3);
        w = 0;
        while (!irq && w < 300) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        check("irq_rise_within_bound", irq, 1'b1);
        xfer(1'b0, 32'h0, 4'hF, 32'h0, rd, ak, er);
        check("irq_rise_time", (rd >= 32'd100 && rd <= 32'd104), 1'b1);
        wr32(32'h0C, 32'h1);
        check("irq_fall", irq, 1'b0);

        // error offsets and partial byte-lane write
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        xfer(1'b0, 32'h1C, 4'hF, 32'h0, rd, ak, er);
        check("bad_off_err", er, 1'b1);
        check("bad_off_ack", ak, 1'b0);
        check("bad_off_data", rd, 32'h0);
        xfer(1'b1, 32'h08, 4'b0010, 32'hAABB_CCDD, rd, ak, er);
        xfer(1'b0, 32'h08, 4'hF, 32'h0, rd, ak, er);
        check("sel_merge", rd, 32'hFFFF_CCFF);
        xfer(1'b0, 32'h14, 4'hF, 32'h0, rd, ak, er);
        check("prescale_off_err", er, !PRE_EN);

        // back-to-back reads, then abandon with one response pending
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 4) begin cyc = 1'b0; stb = 1'b0; end
            @(negedge clk);
            check("b2b_ack", wbi.ack, (i < 4));
        end
        @(posedge clk); #1;

        // reset mid-run with irq high and a request in the reset cycle
        wr32(32'h08, 32'h0);
        wr32(32'h0C, 32'h0);
        wr32(32'h10, 32'h2);
        idle(2);
        check("irq_before_reset", irq, 1'b1);
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
        @(posedge clk); #1;
        stb = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("reset_drops_req", wbi.ack, 1'b0);
        check("reset_clears_irq", irq, 1'b0);
        @(posedge clk); #1;
        cyc = 1'b0;

`ifdef WB_TIMER_PRESCALER_EN
        wr32(32'h10, 32'h0);
        wr32(32'h00, 32'h0);
        wr32(32'h04, 32'h0);
        wr32(32'h14, 32'h3);
        wr32(32'h10, 32'h1);
        idle(40);
        xfer(1'b0, 32'h0, 4'hF, 32'h0, rd, ak, er);
        check("prescale_rate", rd, 32'd10);
        xfer(1'b0, 32'h14, 4'hF, 32'h0, rd, ak, er);
        check("prescale_readback", rd, 32'd3);
`endif

        // randomized traffic
        for (int n = 0; n < 2500; n++) begin
            int o, k;
            rst = ($urandom_range(0, 299) == 0);
            cyc = ($urandom_range(0, 9) != 0);
            stb = ($urandom_range(0, 3) != 0);
            we  = $urandom_range(0, 1);
            o   = $urandom_range(0, 9);
            if (o > 7) o = 4;
            adr = $urandom;
            adr[4:2] = o[2:0];
            sel = 4'($urandom);
            k = $urandom_range(0, 3);
            if (k == 0) wdat = 32'd0;
            else if (k == 1) wdat = $urandom_range(0, 300);
            else wdat = $urandom;
            @(posedge clk); #1;
        end
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        idle(3);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
